memory_mb_dp: RTL and testbench

Banked, multi-read-port memory for a single clock domain. Storage is split into `num_banks` low-order-interleaved banks. Each bank has one write port and one read port. `num_rd_ports` independent read requesters share the banks through per-bank round-robin arbitration with a request/grant handshake. The single write port supports byte enables. The block sits between multiple consumers (for example, parallel lookup engines) and a single producer that fills the table.

---
 rtl/memory_mb_dp_pkg.sv | 41 ++++
 rtl/memory_mb_dp_if.sv | 31 +++
 rtl/memory_mb_dp_rr_arbiter.sv | 40 ++++
 rtl/memory_mb_dp.sv | 134 +++++++++++++
 tb/tb_memory_mb_dp.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_mb_dp_pkg.sv
// Shared address-split and round-robin helpers for the banked multi-read memory.
// Latency: combinational helpers only.
// Backpressure: none; pure functions.
package memory_mb_pkg;

    localparam int MAX_PORTS = 32;

    typedef logic [MAX_PORTS-1:0] port_vec_t;

    function automatic int bank_of(input logic [31:0] addr, input int bank_bits);
        if (bank_bits == 0) begin
            return 0;
        end
        return int'(addr & ((32'd1 << bank_bits) - 32'd1));
    endfunction

    function automatic int row_of(input logic [31:0] addr, input int bank_bits);
        return int'(addr >> bank_bits);
    endfunction

    // One-hot pick of the first requester at or after ptr, wrapping over n ports.
    function automatic port_vec_t rr_pick(input port_vec_t req_vec, input int ptr, input int n);
        port_vec_t gnt;
        bit        found;
        int        idx;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            if (k < n && !found) begin
                idx = (ptr + k) % n;
                if (req_vec[idx[4:0]]) begin
                    gnt[idx[4:0]] = 1'b1;
                    found         = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/memory_mb_dp_if.sv
// Write port plus per-port read request/grant/data bundle for memory_mb_dp.
// Latency: wires only.
// Backpressure: reads hold rd_req/rd_addr until rd_gnt; writes are never stalled.
interface memory_mb_dp_if #(
    parameter int num_mem_entries = 64,
    parameter int data_bit_width  = 32,
    parameter int num_rd_ports    = 2
);
    localparam int addr_bit_width = $clog2(num_mem_entries);
    localparam int be_bit_width   = data_bit_width / 8;

    logic                                     wr_en;
    logic [addr_bit_width-1:0]                wr_addr;
    logic [data_bit_width-1:0]                wr_data;
    logic [be_bit_width-1:0]                  wr_be;
    logic [num_rd_ports-1:0]                  rd_req;
    logic [num_rd_ports*addr_bit_width-1:0]   rd_addr;
    logic [num_rd_ports-1:0]                  rd_gnt;
    logic [num_rd_ports-1:0]                  rd_valid;
    logic [num_rd_ports*data_bit_width-1:0]   rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_req, rd_addr,
        input  rd_gnt, rd_valid, rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_req, rd_addr,
        output rd_gnt, rd_valid, rd_data
    );
endinterface

// File: rtl/memory_mb_dp_rr_arbiter.sv
// Per-bank round-robin arbiter over the read ports targeting that bank.
// Latency: grant is combinational; pointer advances on the grant edge.
// Backpressure: losers are not granted and keep requesting; grants forced off in reset.
module rr_arbiter
    import memory_mb_pkg::*;
#(
    parameter int num_rd_ports = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [num_rd_ports-1:0] req,
    output logic [num_rd_ports-1:0] gnt
);
    localparam int PTR_W = (num_rd_ports > 1) ? $clog2(num_rd_ports) : 1;

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    port_vec_t        pick;
    logic             unused_pick;

    always_comb begin
        pick        = rr_pick(port_vec_t'(req), int'(rr_ptr_q), num_rd_ports);
        unused_pick = ^pick;
        gnt         = rst ? '0 : pick[num_rd_ports-1:0];
        rr_ptr_d    = rr_ptr_q;
        for (int p = 0; p < num_rd_ports; p++) begin
            if (gnt[p]) begin
                rr_ptr_d = PTR_W'((p + 1) % num_rd_ports);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/memory_mb_dp.sv
// Low-order-interleaved banked memory, one byte-enabled write port, N arbitrated read ports.
// Latency: rd_valid/rd_data one cycle after rd_gnt; reads are read-first against a same-edge write.
// Backpressure: per-bank round-robin grant; an ungranted port holds its request.
module memory_mb_dp
    import memory_mb_pkg::*;
#(
    parameter int num_mem_entries = 64,
    parameter int data_bit_width  = 32,
    parameter int num_banks       = 4,
    parameter int num_rd_ports    = 2
) (
    input  logic           clk,
    input  logic           rst,
    memory_mb_dp_if.slave  bus
);
    localparam int addr_bit_width = $clog2(num_mem_entries);
    localparam int bank_bit_width = $clog2(num_banks);
    localparam int be_bit_width   = data_bit_width / 8;
    localparam int DEPTH          = num_mem_entries / num_banks;
    localparam int ROW_W          = (addr_bit_width - bank_bit_width > 0) ? (addr_bit_width - bank_bit_width) : 1;
    localparam int SEL_W          = (bank_bit_width > 0) ? bank_bit_width : 1;

    logic [SEL_W-1:0]          port_bank  [num_rd_ports];
    logic [ROW_W-1:0]          port_row   [num_rd_ports];
    logic [num_rd_ports-1:0]   bank_req   [num_banks];
    logic [num_rd_ports-1:0]   bank_gnt   [num_banks];
    logic [ROW_W-1:0]          bank_row   [num_banks];
    logic                      bank_hit   [num_banks];
    logic [data_bit_width-1:0] bank_rd_d  [num_banks];
    logic [data_bit_width-1:0] bank_rd_q  [num_banks];

    logic [num_rd_ports-1:0]   rd_gnt;
    logic [num_rd_ports-1:0]   rd_valid_q, rd_valid_d;
    logic [SEL_W-1:0]          sel_q      [num_rd_ports];
    logic [SEL_W-1:0]          sel_d      [num_rd_ports];
    logic [data_bit_width-1:0] hold_q     [num_rd_ports];
    logic [data_bit_width-1:0] hold_d     [num_rd_ports];
    logic [num_rd_ports*data_bit_width-1:0] rd_data_flat;

    logic [SEL_W-1:0]          wr_bank;
    logic [ROW_W-1:0]          wr_row;

    assign wr_bank = SEL_W'(bank_of(32'(bus.wr_addr), bank_bit_width));
    assign wr_row  = ROW_W'(row_of(32'(bus.wr_addr), bank_bit_width));

    always_comb begin
        for (int p = 0; p < num_rd_ports; p++) begin
            port_bank[p] = SEL_W'(bank_of(32'(bus.rd_addr[p*addr_bit_width +: addr_bit_width]), bank_bit_width));
            port_row[p]  = ROW_W'(row_of(32'(bus.rd_addr[p*addr_bit_width +: addr_bit_width]), bank_bit_width));
        end
        for (int b = 0; b < num_banks; b++) begin
            bank_req[b] = '0;
            for (int p = 0; p < num_rd_ports; p++) begin
                bank_req[b][p] = bus.rd_req[p] && (int'(port_bank[p]) == b);
            end
        end
    end

    for (genvar b = 0; b < num_banks; b++) begin : g_bank
        logic [data_bit_width-1:0] mem_q [0:DEPTH-1];

        rr_arbiter #(.num_rd_ports(num_rd_ports)) u_arb (
            .clk (clk),
            .rst (rst),
            .req (bank_req[b]),
            .gnt (bank_gnt[b])
        );

        always_ff @(posedge clk) begin
            if (!rst && bus.wr_en && (int'(wr_bank) == b)) begin
                for (int i = 0; i < be_bit_width; i++) begin
                    if (bus.wr_be[i]) begin
                        mem_q[wr_row][8*i +: 8] <= bus.wr_data[8*i +: 8];
                    end
                end
            end
        end

        // Bank read register only loads on a grant, so it sees pre-write contents.
        assign bank_rd_d[b] = bank_hit[b] ? mem_q[bank_row[b]] : bank_rd_q[b];
    end

    always_comb begin
        rd_gnt = '0;
        for (int b = 0; b < num_banks; b++) begin
            bank_hit[b] = |bank_gnt[b];
            bank_row[b] = '0;
            for (int p = 0; p < num_rd_ports; p++) begin
                if (bank_gnt[b][p]) begin
                    bank_row[b] = port_row[p];
                end
                rd_gnt[p] = rd_gnt[p] | bank_gnt[b][p];
            end
        end
    end

    // Bank registers are shared across ports, so each port keeps its own copy for the hold.
    always_comb begin
        rd_valid_d   = rd_gnt;
        rd_data_flat = '0;
        for (int p = 0; p < num_rd_ports; p++) begin
            sel_d[p]  = rd_gnt[p] ? port_bank[p] : sel_q[p];
            hold_d[p] = rd_valid_q[p] ? bank_rd_q[sel_q[p]] : hold_q[p];
            rd_data_flat[p*data_bit_width +: data_bit_width] = hold_d[p];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= '0;
            for (int p = 0; p < num_rd_ports; p++) begin
                sel_q[p]  <= '0;
                hold_q[p] <= '0;
            end
            for (int b = 0; b < num_banks; b++) begin
                bank_rd_q[b] <= '0;
            end
        end else begin
            rd_valid_q <= rd_valid_d;
            for (int p = 0; p < num_rd_ports; p++) begin
                sel_q[p]  <= sel_d[p];
                hold_q[p] <= hold_d[p];
            end
            for (int b = 0; b < num_banks; b++) begin
                bank_rd_q[b] <= bank_rd_d[b];
            end
        end
    end

    assign bus.rd_gnt   = rd_gnt;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_flat;

endmodule

// File: tb/tb_memory_mb_dp.sv
// Bench for memory_mb_dp: directed cases on the 4-bank/2-port build, then random
// traffic on three builds (4b/2p, 1b/3p, 8b/1p) against an array-and-queue reference.
module tb_memory_mb_dp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [2:0]  req   [3];
    logic [5:0]  raddr [3][3];
    logic [2:0]  gnt_o [3];
    logic [2:0]  vld_o [3];
    logic [31:0] dat_o [3][3];

    memory_mb_dp_if #(.num_mem_entries(64), .data_bit_width(32), .num_rd_ports(2)) if0 ();
    memory_mb_dp_if #(.num_mem_entries(64), .data_bit_width(32), .num_rd_ports(3)) if1 ();
    memory_mb_dp_if #(.num_mem_entries(64), .data_bit_width(32), .num_rd_ports(1)) if2 ();

    memory_mb_dp #(.num_mem_entries(64), .data_bit_width(32), .num_banks(4), .num_rd_ports(2))
        u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    memory_mb_dp #(.num_mem_entries(64), .data_bit_width(32), .num_banks(1), .num_rd_ports(3))
        u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    memory_mb_dp #(.num_mem_entries(64), .data_bit_width(32), .num_banks(8), .num_rd_ports(1))
        u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.wr_en = wr_en;  assign if0.wr_addr = wr_addr;  assign if0.wr_data = wr_data;  assign if0.wr_be = wr_be;
    assign if1.wr_en = wr_en;  assign if1.wr_addr = wr_addr;  assign if1.wr_data = wr_data;  assign if1.wr_be = wr_be;
    assign if2.wr_en = wr_en;  assign if2.wr_addr = wr_addr;  assign if2.wr_data = wr_data;  assign if2.wr_be = wr_be;

    assign if0.rd_req  = req[0][1:0];
    assign if0.rd_addr = {raddr[0][1], raddr[0][0]};
    assign if1.rd_req  = req[1];
    assign if1.rd_addr = {raddr[1][2], raddr[1][1], raddr[1][0]};
    assign if2.rd_req  = req[2][0:0];
    assign if2.rd_addr = raddr[2][0];

    assign gnt_o[0] = {1'b0, if0.rd_gnt};
    assign vld_o[0] = {1'b0, if0.rd_valid};
    assign gnt_o[1] = if1.rd_gnt;
    assign vld_o[1] = if1.rd_valid;
    assign gnt_o[2] = {2'b00, if2.rd_gnt};
    assign vld_o[2] = {2'b00, if2.rd_valid};
    assign dat_o[0][0] = if0.rd_data[31:0];
    assign dat_o[0][1] = if0.rd_data[63:32];
    assign dat_o[0][2] = 32'h0;
    assign dat_o[1][0] = if1.rd_data[31:0];
    assign dat_o[1][1] = if1.rd_data[63:32];
    assign dat_o[1][2] = if1.rd_data[95:64];
    assign dat_o[2][0] = if2.rd_data;
    assign dat_o[2][1] = 32'h0;
    assign dat_o[2][2] = 32'h0;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Reference state for the random phase.
    int          np_c [3] = '{2, 3, 1};
    int          nb_c [3] = '{4, 1, 8};
    logic [31:0] mdl  [64];
    int          ptr  [3][8];
    logic [31:0] exp_hold [3][3];
    logic [2:0]  exp_vld  [3];
    bit          pend  [3][3];
    int          waitc [3][3];

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_be   = '0;
        for (int c = 0; c < 3; c++) begin
            req[c] = '0;
            for (int p = 0; p < 3; p++) raddr[c][p] = '0;
        end

        // Reset: pending request not granted, outputs cleared.
        cyc();
        req[0] = 3'b001; raddr[0][0] = 6'd5;
        smp(); chk("rst_gnt", 32'(gnt_o[0]), 32'h0);
        cyc();
        smp();
        chk("rst_vld", 32'(vld_o[0]), 32'h0);
        chk("rst_dat0", dat_o[0][0], 32'h0);
        chk("rst_dat1", dat_o[0][1], 32'h0);
        cyc(); rst = 1'b0; req[0] = '0;

        // Byte-enable writes, then a be=0 write that must not change anything.
        wr_en = 1'b1; wr_addr = 6'd5; wr_data = 32'hAABBCCDD; wr_be = 4'hF;
        cyc(); wr_data = 32'h11223344; wr_be = 4'h5;
        cyc(); wr_data = 32'h00000000; wr_be = 4'h0;
        cyc(); wr_en = 1'b0; req[0] = 3'b001; raddr[0][0] = 6'd5;
        smp(); chk("be_gnt", 32'(gnt_o[0]), 32'h1);
        cyc(); req[0] = '0;
        smp();
        chk("be_vld", 32'(vld_o[0]), 32'h1);
        chk("be_dat", dat_o[0][0], 32'hAA22CC44);

        // Two ports on different banks in the same cycle.
        cyc(); wr_en = 1'b1; wr_be = 4'hF; wr_addr = 6'd4;  wr_data = 32'h40404040;
        cyc(); wr_addr = 6'd7;  wr_data = 32'h70707070;
        cyc(); wr_addr = 6'd8;  wr_data = 32'h80808080;
        cyc(); wr_addr = 6'd12; wr_data = 32'hC0C0C0C0;
        cyc(); wr_en = 1'b0; req[0] = 3'b011; raddr[0][0] = 6'd4; raddr[0][1] = 6'd7;
        smp(); chk("par_gnt", 32'(gnt_o[0]), 32'h3);
        cyc(); req[0] = '0;
        smp();
        chk("par_vld", 32'(vld_o[0]), 32'h3);
        chk("par_dat0", dat_o[0][0], 32'h40404040);
        chk("par_dat1", dat_o[0][1], 32'h70707070);

        // Same-bank conflict after reset alternates starting at port 0.
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0; req[0] = 3'b011; raddr[0][0] = 6'd8; raddr[0][1] = 6'd12;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk($sformatf("rr_gnt%0d", k), 32'(gnt_o[0]), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k > 0) chk($sformatf("rr_vld%0d", k), 32'(vld_o[0]), (k % 2 == 0) ? 32'h2 : 32'h1);
            cyc();
        end
        req[0] = '0;
        smp();
        chk("rr_vld_last", 32'(vld_o[0]), 32'h2);
        chk("rr_dat0", dat_o[0][0], 32'h80808080);
        chk("rr_dat1", dat_o[0][1], 32'hC0C0C0C0);

        // Same-address read and write on one edge: read sees the old word.
        cyc(); wr_en = 1'b1; wr_addr = 6'd3; wr_data = 32'h1; wr_be = 4'hF;
        cyc(); wr_data = 32'h2; req[0] = 3'b001; raddr[0][0] = 6'd3;
        smp(); chk("col_gnt", 32'(gnt_o[0]), 32'h1);
        cyc(); wr_en = 1'b0;
        smp();
        chk("col_vld", 32'(vld_o[0]), 32'h1);
        chk("col_old", dat_o[0][0], 32'h1);
        cyc(); req[0] = '0;
        smp(); chk("col_new", dat_o[0][0], 32'h2);

        // Reset with a pending read and a write in flight.
        cyc(); wr_en = 1'b1; wr_addr = 6'd9; wr_data = 32'h99999999;
        cyc(); rst = 1'b1; wr_data = 32'hDEADBEEF; req[0] = 3'b010; raddr[0][1] = 6'd9;
        smp(); chk("mrst_gnt", 32'(gnt_o[0]), 32'h0);
        cyc(); rst = 1'b0; wr_en = 1'b0;
        smp();
        chk("mrst_vld", 32'(vld_o[0]), 32'h0);
        chk("mrst_dat1", dat_o[0][1], 32'h0);
        chk("mrst_regnt", 32'(gnt_o[0]), 32'h2);
        cyc(); req[0] = 3'b011; raddr[0][0] = 6'd0; raddr[0][1] = 6'd4;
        smp();
        chk("mrst_keep", dat_o[0][1], 32'h99999999);
        chk("mrst_ptr0", 32'(gnt_o[0]), 32'h1);
        cyc(); req[0] = '0;

        // Random phase: reset, preload every word, then mixed traffic on all builds.
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        for (int a = 0; a < 64; a++) begin
            wr_en = 1'b1; wr_addr = 6'(a); wr_data = $urandom; wr_be = 4'hF;
            mdl[a] = wr_data;
            cyc();
        end
        wr_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            exp_vld[c] = '0;
            for (int b = 0; b < 8; b++) ptr[c][b] = 0;
            for (int p = 0; p < 3; p++) begin
                exp_hold[c][p] = '0; pend[c][p] = 1'b0; waitc[c][p] = 0;
            end
        end

        for (int t = 0; t < 1500; t++) begin
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = 6'($urandom_range(0, 63));
            wr_data = $urandom;
            wr_be   = 4'($urandom_range(0, 15));
            for (int c = 0; c < 3; c++) begin
                for (int p = 0; p < np_c[c]; p++) begin
                    if (!pend[c][p] && $urandom_range(0, 2) != 0) begin
                        pend[c][p]  = 1'b1;
                        raddr[c][p] = 6'($urandom_range(0, 63));
                    end
                    req[c][p] = pend[c][p];
                end
            end
            smp();
            for (int c = 0; c < 3; c++) begin
                logic [2:0] eg;
                eg = '0;
                for (int b = 0; b < nb_c[c]; b++) begin
                    bit found;
                    found = 1'b0;
                    for (int k = 0; k < np_c[c]; k++) begin
                        int p;
                        p = (ptr[c][b] + k) % np_c[c];
                        if (!found && pend[c][p] && (int'(raddr[c][p]) % nb_c[c] == b)) begin
                            found     = 1'b1;
                            eg[p]     = 1'b1;
                            ptr[c][b] = (p + 1) % np_c[c];
                        end
                    end
                end
                chk($sformatf("c%0d_gnt", c), 32'(gnt_o[c]), 32'(eg));
                chk($sformatf("c%0d_vld", c), 32'(vld_o[c]), 32'(exp_vld[c]));
                for (int p = 0; p < np_c[c]; p++) begin
                    chk($sformatf("c%0d_dat%0d", c, p), dat_o[c][p], exp_hold[c][p]);
                    if (eg[p]) begin
                        chk($sformatf("c%0d_starve%0d", c, p), 32'(waitc[c][p] <= np_c[c] - 1), 32'h1);
                        exp_hold[c][p] = mdl[raddr[c][p]];
                        pend[c][p]     = 1'b0;
                        waitc[c][p]    = 0;
                    end else if (pend[c][p]) begin
                        waitc[c][p]++;
                    end
                end
                exp_vld[c] = eg;
            end
            if (wr_en) begin
                for (int i = 0; i < 4; i++) begin
                    if (wr_be[i]) mdl[wr_addr][8*i +: 8] = wr_data[8*i +: 8];
                end
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
